// File: rtl/sort_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : sort_result_checker
// Description : Self-checking consumer for the bubble-sort stage. It snoops
//               every word pushed into the sorter and drains the sorter's get
//               port through the RDY/EN handshake. The drained words must be
//               in non-decreasing signed order and must match the inputs in
//               both arithmetic sum and XOR checksum. Pass/fail and the
//               diagnostics are reported to the testbench top.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK        in   clock
//   RST_N      in   synchronous active-low reset
//   start      in   one-cycle pulse that arms a new batch
//   snoop_en   in   copy of sorter EN_put
//   snoop_x    in   copy of sorter put_x (W bits, signed)
//   RDY_get    in   sorter get method ready
//   get        in   sorter get method value (W bits, signed)
//   EN_get     out  get method enable (combinational)
//   busy       out  high in COLLECT or CHECK
//   done       out  high in DONE
//   pass       out  result, meaningful while done=1
//   err_order  out  sticky: out-of-order pair seen
//   err_sum    out  sum/XOR/count mismatch between input and output sets
//   err_count  out  sticky: more than N snooped inputs
//   bad_idx    out  output index of the first out-of-order word, 0 if none
//   out_cnt    out  words drained in the current batch
// ============================================================================
module sort_result_checker #(
  parameter int N = 5,
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic         snoop_en,
  input  logic [W-1:0] snoop_x,
  input  logic         RDY_get,
  input  logic [W-1:0] get,
  output logic         EN_get,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         err_order,
  output logic         err_sum,
  output logic         err_count,
  output logic [7:0]   bad_idx,
  output logic [7:0]   out_cnt
);

  // Accumulators carry 8 guard bits, enough for 255 sign-extended words.
  localparam int         c_ACC_W = W + 8;
  localparam logic [7:0] c_N8    = 8'(N);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_next;

  logic [7:0]                  r_in_cnt;
  logic [7:0]                  r_out_cnt;
  logic [7:0]                  r_bad_idx;
  logic signed [c_ACC_W-1:0]   r_in_sum;
  logic signed [c_ACC_W-1:0]   r_out_sum;
  logic [W-1:0]                r_in_xor;
  logic [W-1:0]                r_out_xor;
  logic [W-1:0]                r_prev;
  logic                        r_err_order;
  logic                        r_err_sum;
  logic                        r_err_count;

  logic                        w_clear;
  logic                        w_en_get;
  logic                        w_snoop_acc;
  logic                        w_snoop_over;
  logic                        w_order_bad;
  logic signed [c_ACC_W-1:0]   w_snoop_ext;
  logic signed [c_ACC_W-1:0]   w_get_ext;

  // start is only honoured when not busy; it clears everything for the batch.
  assign w_clear      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_en_get     = RDY_get && (r_state == S_COLLECT) && (r_out_cnt < c_N8);
  assign w_snoop_acc  = (r_state == S_COLLECT) && snoop_en && (r_in_cnt < c_N8);
  assign w_snoop_over = (r_state == S_COLLECT) && snoop_en && (r_in_cnt == c_N8);
  // The first drained word has no predecessor, so it can never be out of order.
  assign w_order_bad  = w_en_get && (r_out_cnt != 8'd0) &&
                        ($signed(get) < $signed(r_prev));

  assign w_snoop_ext  = {{8{snoop_x[W-1]}}, snoop_x};
  assign w_get_ext    = {{8{get[W-1]}}, get};

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_COLLECT;
      // Leave COLLECT on the edge that takes the final word.
      S_COLLECT: if (w_en_get && (r_out_cnt == c_N8 - 8'd1)) w_next = S_CHECK;
      S_CHECK:   w_next = S_DONE;
      S_DONE:    if (start) w_next = S_COLLECT;
      default:   w_next = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_bad_idx   <= '0;
      r_in_sum    <= '0;
      r_out_sum   <= '0;
      r_in_xor    <= '0;
      r_out_xor   <= '0;
      r_prev      <= '0;
      r_err_order <= 1'b0;
      r_err_sum   <= 1'b0;
      r_err_count <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_in_cnt    <= '0;
        r_out_cnt   <= '0;
        r_bad_idx   <= '0;
        r_in_sum    <= '0;
        r_out_sum   <= '0;
        r_in_xor    <= '0;
        r_out_xor   <= '0;
        r_prev      <= '0;
        r_err_order <= 1'b0;
        r_err_sum   <= 1'b0;
        r_err_count <= 1'b0;
      end else begin
        if (w_snoop_acc) begin
          r_in_sum <= r_in_sum + w_snoop_ext;
          r_in_xor <= r_in_xor ^ snoop_x;
          r_in_cnt <= r_in_cnt + 8'd1;
        end
        if (w_snoop_over) begin
          r_err_count <= 1'b1;
        end
        if (w_en_get) begin
          r_out_sum <= r_out_sum + w_get_ext;
          r_out_xor <= r_out_xor ^ get;
          r_out_cnt <= r_out_cnt + 8'd1;
          r_prev    <= get;
        end
        if (w_order_bad) begin
          r_err_order <= 1'b1;
          // Index 0 can never be an offender, so 0 doubles as "not captured".
          if (r_bad_idx == 8'd0) begin
            r_bad_idx <= r_out_cnt;
          end
        end
        if (r_state == S_CHECK) begin
          r_err_sum <= (r_in_sum != r_out_sum) || (r_in_xor != r_out_xor) ||
                       (r_in_cnt != c_N8);
        end
      end
    end
  end

  assign EN_get    = w_en_get;
  assign busy      = (r_state == S_COLLECT) || (r_state == S_CHECK);
  assign done      = (r_state == S_DONE);
  assign pass      = done && !r_err_order && !r_err_sum && !r_err_count;
  assign err_order = r_err_order;
  assign err_sum   = r_err_sum;
  assign err_count = r_err_count;
  assign bad_idx   = r_bad_idx;
  assign out_cnt   = r_out_cnt;

endmodule
`default_nettype wire
